// File: rtl/exe_stage_mc.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_mc
// Brief    : Execute stage with single-cycle ALU, iterative radix-2^BPC
//            multiplier (MUL/MLA) and integrated EXE/MEM pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage_mc #(
    parameter int DATA_W = 32,
    parameter int BPC    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [3:0]        EXE_CMD,
    input  logic              mul_en,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] Val_Rn,
    input  logic [DATA_W-1:0] Val_2,
    input  logic [DATA_W-1:0] Val_Rs,
    input  logic [3:0]        SR,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              S_in,
    input  logic [DATA_W-1:0] ST_val_in,
    input  logic [3:0]        Dest_in,
    input  logic              freeze,
    input  logic              flush,
    output logic              stall,
    output logic              valid_out,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              status_we,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] ST_val,
    output logic [3:0]        Dest,
    output logic [3:0]        status
);

    localparam int STEPS = DATA_W / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STEPS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]  r_mplier;
    logic [DATA_W-1:0]  r_acc;
    logic [CNT_W-1:0]   r_cnt;

    // SR N/Z bits are never consumed: flags are recomputed from the result.
    logic w_unused_flags;
    assign w_unused_flags = &{1'b0, SR[3:2]};

    // ------------------------------------------------------------------
    // Multiplier datapath: one BPC-bit digit of the multiplier per cycle
    // ------------------------------------------------------------------
    logic [DATA_W+BPC-1:0] w_mcand_x;
    logic [DATA_W+BPC-1:0] w_digit_x;
    logic [DATA_W+BPC-1:0] w_prod;
    logic [DATA_W-1:0]     w_acc_next;
    logic                  w_mul_done;

    assign w_mcand_x  = {{BPC{1'b0}}, r_mcand};
    assign w_digit_x  = {{DATA_W{1'b0}}, r_mplier[BPC-1:0]};
    assign w_prod     = w_mcand_x * w_digit_x;
    assign w_acc_next = r_acc + w_prod[DATA_W-1:0];
    assign w_mul_done = (r_state == S_BUSY) && (r_cnt == '0);

    // Upstream must hold a multiply until its final iteration cycle.
    assign stall = valid_in & mul_en & ~w_mul_done;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_b_op;
    logic              w_cin;
    logic              w_arith;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic              w_alu_v;

    // Adder operand selection: subtraction is A + ~B + carry-in.
    always_comb begin
        w_b_op  = Val_2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (EXE_CMD)
            4'b0010: begin w_arith = 1'b1; end
            4'b0011: begin w_arith = 1'b1; w_cin = SR[1]; end
            4'b0100: begin w_arith = 1'b1; w_b_op = ~Val_2; w_cin = 1'b1; end
            4'b0101: begin w_arith = 1'b1; w_b_op = ~Val_2; w_cin = SR[1]; end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, Val_Rn} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_cin};

    // Result and C/V selection; non-arithmetic ops pass C/V through from SR.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = SR[1];
        w_alu_v   = SR[0];
        if (w_arith) begin
            w_alu_res = w_sum[DATA_W-1:0];
            w_alu_c   = w_sum[DATA_W];
            w_alu_v   = (Val_Rn[DATA_W-1] == w_b_op[DATA_W-1]) &&
                        (w_sum[DATA_W-1] != Val_Rn[DATA_W-1]);
        end else begin
            case (EXE_CMD)
                4'b0001: w_alu_res = Val_2;
                4'b1001: w_alu_res = ~Val_2;
                4'b0110: w_alu_res = Val_Rn & Val_2;
                4'b0111: w_alu_res = Val_Rn | Val_2;
                4'b1000: w_alu_res = Val_Rn ^ Val_2;
                default: w_alu_res = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture selection for the output register
    // ------------------------------------------------------------------
    logic              w_cap_mul;
    logic              w_cap_alu;
    logic              w_cap;
    logic [DATA_W-1:0] w_res;
    logic [3:0]        w_flags;

    assign w_cap_mul = valid_in & mul_en & w_mul_done;
    assign w_cap_alu = valid_in & ~mul_en & (r_state == S_IDLE);
    assign w_cap     = w_cap_mul | w_cap_alu;
    assign w_res     = w_cap_mul ? w_acc_next : w_alu_res;
    assign w_flags   = {w_res[DATA_W-1], (w_res == '0),
                        w_cap_mul ? SR[1] : w_alu_c,
                        w_cap_mul ? SR[0] : w_alu_v};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: flush abandons a multiply, freeze holds everything.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else if (!freeze) begin
            case (r_state)
                S_IDLE: if (valid_in && mul_en) w_state_next = S_BUSY;
                S_BUSY: if (r_cnt == '0)        w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Multiplier registers: load on launch, iterate while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (!flush && !freeze) begin
            if (r_state == S_IDLE) begin
                if (valid_in && mul_en) begin
                    r_mcand  <= Val_2;
                    r_mplier <= Val_Rs;
                    r_acc    <= acc_en ? Val_Rn : '0;
                    r_cnt    <= C_CNT_LAST;
                end
            end else begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << BPC;
                r_mplier <= r_mplier >> BPC;
                r_cnt    <= r_cnt - CNT_W'(1);
            end
        end
    end

    // EXE/MEM pipeline register; bubbles clear only the valid/enable bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            WB_en      <= 1'b0;
            MEM_R_EN   <= 1'b0;
            MEM_W_EN   <= 1'b0;
            status_we  <= 1'b0;
            ALU_result <= '0;
            ST_val     <= '0;
            Dest       <= '0;
            status     <= '0;
        end else if (flush) begin
            valid_out  <= 1'b0;
            WB_en      <= 1'b0;
            MEM_R_EN   <= 1'b0;
            MEM_W_EN   <= 1'b0;
            status_we  <= 1'b0;
        end else if (!freeze) begin
            valid_out  <= w_cap;
            WB_en      <= w_cap & WB_en_in;
            MEM_R_EN   <= w_cap & MEM_R_EN_in;
            MEM_W_EN   <= w_cap & MEM_W_EN_in;
            status_we  <= w_cap & S_in;
            if (w_cap) begin
                ALU_result <= w_res;
                ST_val     <= ST_val_in;
                Dest       <= Dest_in;
                status     <= w_flags;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage_mc
// Brief    : Directed self-checking bench for exe_stage_mc (BPC = 2, 1, 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mul_en, acc_en;
    logic [3:0]  EXE_CMD, SR, Dest_in;
    logic [31:0] Val_Rn, Val_2, Val_Rs, ST_val_in;
    logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in, S_in, freeze, flush;

    logic        stall, valid_out, WB_en, MEM_R_EN, MEM_W_EN, status_we;
    logic [31:0] ALU_result, ST_val;
    logic [3:0]  Dest, status;

    logic        stall_1, valid_out_1, WB_en_1, MEM_R_EN_1, MEM_W_EN_1, status_we_1;
    logic [31:0] ALU_result_1, ST_val_1;
    logic [3:0]  Dest_1, status_1;

    logic        stall_4, valid_out_4, WB_en_4, MEM_R_EN_4, MEM_W_EN_4, status_we_4;
    logic [31:0] ALU_result_4, ST_val_4;
    logic [3:0]  Dest_4, status_4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_stage_mc #(.DATA_W(32), .BPC(2)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .EXE_CMD(EXE_CMD),
        .mul_en(mul_en), .acc_en(acc_en), .Val_Rn(Val_Rn), .Val_2(Val_2),
        .Val_Rs(Val_Rs), .SR(SR), .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
        .MEM_W_EN_in(MEM_W_EN_in), .S_in(S_in), .ST_val_in(ST_val_in),
        .Dest_in(Dest_in), .freeze(freeze), .flush(flush), .stall(stall),
        .valid_out(valid_out), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN),
        .MEM_W_EN(MEM_W_EN), .status_we(status_we), .ALU_result(ALU_result),
        .ST_val(ST_val), .Dest(Dest), .status(status)
    );

    exe_stage_mc #(.DATA_W(32), .BPC(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .EXE_CMD(EXE_CMD),
        .mul_en(mul_en), .acc_en(acc_en), .Val_Rn(Val_Rn), .Val_2(Val_2),
        .Val_Rs(Val_Rs), .SR(SR), .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
        .MEM_W_EN_in(MEM_W_EN_in), .S_in(S_in), .ST_val_in(ST_val_in),
        .Dest_in(Dest_in), .freeze(freeze), .flush(flush), .stall(stall_1),
        .valid_out(valid_out_1), .WB_en(WB_en_1), .MEM_R_EN(MEM_R_EN_1),
        .MEM_W_EN(MEM_W_EN_1), .status_we(status_we_1), .ALU_result(ALU_result_1),
        .ST_val(ST_val_1), .Dest(Dest_1), .status(status_1)
    );

    exe_stage_mc #(.DATA_W(32), .BPC(4)) dut4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .EXE_CMD(EXE_CMD),
        .mul_en(mul_en), .acc_en(acc_en), .Val_Rn(Val_Rn), .Val_2(Val_2),
        .Val_Rs(Val_Rs), .SR(SR), .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
        .MEM_W_EN_in(MEM_W_EN_in), .S_in(S_in), .ST_val_in(ST_val_in),
        .Dest_in(Dest_in), .freeze(freeze), .flush(flush), .stall(stall_4),
        .valid_out(valid_out_4), .WB_en(WB_en_4), .MEM_R_EN(MEM_R_EN_4),
        .MEM_W_EN(MEM_W_EN_4), .status_we(status_we_4), .ALU_result(ALU_result_4),
        .ST_val(ST_val_4), .Dest(Dest_4), .status(status_4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; registered outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 0; mul_en = 0; acc_en = 0; EXE_CMD = 4'b0000;
        Val_Rn = 0; Val_2 = 0; Val_Rs = 0; SR = 4'b0000; ST_val_in = 0;
        WB_en_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; S_in = 0; Dest_in = 0;
        freeze = 0; flush = 0;
    endtask

    // Squash everything in flight so all three instances start from IDLE.
    task automatic clear_all();
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
    endtask

    int lat1, lat2, lat4;
    logic [31:0] res1, res2, res4;
    logic [3:0]  st2;

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();
        chk("rst_valid_out", valid_out, 0);
        chk("rst_alu_result", ALU_result, 0);
        chk("rst_status", status, 0);
        chk("rst_status_we", status_we, 0);
        chk("rst_stall_low", stall, 0);
        valid_in = 1; mul_en = 1;
        #1;
        chk("rst_stall_eq", stall, 1);
        idle_inputs();
        tick();

        // ADD overflow
        rst = 0;
        valid_in = 1; EXE_CMD = 4'b0010; Val_Rn = 32'h7FFF_FFFF; Val_2 = 32'h1;
        S_in = 1; WB_en_in = 1; Dest_in = 4'd3; ST_val_in = 32'hCAFE_0001;
        tick();
        chk("add_result", ALU_result, 32'h8000_0000);
        chk("add_status", status, 4'b1001);
        chk("add_status_we", status_we, 1);
        chk("add_valid", valid_out, 1);
        chk("add_wb_en", WB_en, 1);
        chk("add_dest", Dest, 3);
        chk("add_st_val", ST_val, 32'hCAFE_0001);

        // SUB equal operands
        EXE_CMD = 4'b0100; Val_Rn = 32'd5; Val_2 = 32'd5;
        tick();
        chk("sub_result", ALU_result, 0);
        chk("sub_status", status, 4'b0110);

        // MVN, C/V from SR
        EXE_CMD = 4'b1001; Val_2 = 0; SR = 4'b0011; MEM_W_EN_in = 1;
        tick();
        chk("mvn_result", ALU_result, 32'hFFFF_FFFF);
        chk("mvn_status", status, 4'b1011);
        chk("mvn_mem_w", MEM_W_EN, 1);

        // MUL 0x12345678 * 0x10, launched in cycle 0
        valid_in = 1; mul_en = 1; acc_en = 0; MEM_W_EN_in = 0; SR = 4'b0000;
        Val_2 = 32'h1234_5678; Val_Rs = 32'h10; Val_Rn = 32'hDEAD_BEEF; Dest_in = 4'd7;
        #1;
        chk("mul_stall_c0", stall, 1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("mul_bubble_c%0d", c), valid_out, 0);
            chk($sformatf("mul_bubble_we_c%0d", c), status_we, 0);
            #1;
            chk($sformatf("mul_stall_c%0d", c), stall, (c < 16) ? 1 : 0);
        end
        tick();
        chk("mul_valid_c17", valid_out, 1);
        chk("mul_result", ALU_result, 32'h2345_6780);
        chk("mul_status", status, 4'b0000);
        chk("mul_dest", Dest, 7);
        clear_all();

        // MLA 0xFFFFFFFF*3 + 4 on all three BPC variants
        valid_in = 1; mul_en = 1; acc_en = 1; S_in = 1;
        Val_2 = 32'hFFFF_FFFF; Val_Rs = 32'd3; Val_Rn = 32'd4; SR = 4'b0101;
        lat1 = 0; lat2 = 0; lat4 = 0; res1 = 0; res2 = 0; res4 = 0; st2 = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (valid_out   && lat2 == 0) begin lat2 = c; res2 = ALU_result; st2 = status; end
            if (valid_out_1 && lat1 == 0) begin lat1 = c; res1 = ALU_result_1; end
            if (valid_out_4 && lat4 == 0) begin lat4 = c; res4 = ALU_result_4; end
        end
        chk("mla_lat_bpc2", lat2, 17);
        chk("mla_lat_bpc1", lat1, 33);
        chk("mla_lat_bpc4", lat4, 9);
        chk("mla_res_bpc2", res2, 32'h1);
        chk("mla_res_bpc1", res1, 32'h1);
        chk("mla_res_bpc4", res4, 32'h1);
        chk("mla_status", st2, 4'b0001);
        clear_all();

        // MUL with 3 frozen cycles mid-BUSY
        valid_in = 1; mul_en = 1; acc_en = 0;
        Val_2 = 32'h1234_5678; Val_Rs = 32'h10;
        lat2 = 0; res2 = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (valid_out && lat2 == 0) begin lat2 = c; res2 = ALU_result; end
            freeze = (c >= 5 && c <= 7);
        end
        chk("frz_latency", lat2, 20);
        chk("frz_result", res2, 32'h2345_6780);
        clear_all();

        // MUL flushed in cycle 5, then ADD 2+3
        valid_in = 1; mul_en = 1; Val_2 = 32'h1234_5678; Val_Rs = 32'h10;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) flush = 1;
        end
        tick();
        chk("flush_valid_c6", valid_out, 0);
        flush = 0; mul_en = 0; EXE_CMD = 4'b0010; Val_Rn = 32'd2; Val_2 = 32'd3;
        WB_en_in = 1;
        #1;
        chk("flush_stall_c6", stall, 0);
        tick();
        chk("flush_add_valid", valid_out, 1);
        chk("flush_add_result", ALU_result, 32'd5);
        idle_inputs();
        tick();
        chk("final_bubble", valid_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised execute stage with integrated EXE/MEM pipeline register, adding an iterative multi-cycle multiplier (MUL/MLA) next to the single-cycle ALU path. It sits between the ID/EXE register and the memory stage. It back-pressures the front of the pipeline with `stall` while a multiply iterates, and it honours hazard-unit `freeze` and branch `flush`. Datapath width and multiplier bits-per-cycle are generic.

## Interface
- `DATA_W`, 32: datapath width.
- `BPC`, 2: multiplier bits retired per cycle. Must divide `DATA_W`. `STEPS = DATA_W/BPC`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `valid_in`  in  1  instruction present at stage input.
- `EXE_CMD`  in  4  ALU opcode: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
- `mul_en`, `acc_en`  in  1 each  multiply / accumulate (MLA) select. `acc_en` is ignored unless `mul_en` is set.
- `Val_Rn`, `Val_2`, `Val_Rs`  in  DATA_W each  ALU operands; `Val_Rs` is the multiplier.
- `SR`  in  4  current flags {N,Z,C,V}.
- `WB_en_in`, `MEM_R_EN_in`, `MEM_W_EN_in`, `S_in`  in  1 each  control passthrough; `S_in` requests a flag update.
- `ST_val_in`  in  DATA_W  store data.
- `Dest_in`  in  4  destination register.
- `freeze`, `flush`  in  1 each  hold / squash.
- `stall`  out  1  combinational; upstream holds its instruction while high.
- `valid_out`, `WB_en`, `MEM_R_EN`, `MEM_W_EN`, `status_we`  out  1 each  registered.
- `ALU_result`, `ST_val`  out  DATA_W  registered.
- `Dest`  out  4; `status`  out  4 {N,Z,C,V}; both registered.

## Operation
- FSM has two states: IDLE and BUSY. It holds `mcand`, `mplier` (DATA_W) and `acc` (DATA_W), plus a down-counter `cnt` of width clog2(STEPS).
- Non-multiply instruction (`valid_in & ~mul_en`) in IDLE:
  - The ALU result and flags are computed combinationally.
  - The output register captures them at the next edge, with `valid_out=1`.
  - Arithmetic wraps modulo 2^DATA_W.
  - For ADD/ADC/SUB/SBC: C = carry out, with SUB defined as A + ~B + 1. V = signed overflow.
  - For logic ops and MOV/MVN: C and V are taken from `SR`.
- Multiply accepted in IDLE (`valid_in & mul_en`):
  - Load `mcand=Val_2` and `mplier=Val_Rs`.
  - Load `acc=acc_en ? Val_Rn : 0`.
  - Set `cnt=STEPS-1`; go to BUSY.
- BUSY, each cycle:
  - `acc += (mplier[BPC-1:0] * mcand)` truncated to DATA_W.
  - `mcand <<= BPC`, `mplier >>= BPC`, `cnt--`.
  - When `cnt==0`, the updated acc is written to `ALU_result` and the FSM returns to IDLE.
- Multiply result is the low DATA_W bits of `Rs*Rm (+Rn)`. N and Z are taken from the result; C and V are taken from `SR`.
- `stall = valid_in & mul_en & ~(state==BUSY & cnt==0)`.
- While `stall` is high, or `valid_in` is low, the output register loads a bubble: all valid and enable bits are 0, data fields are don't-care.
- `status_we = valid & S_in` of the captured instruction.
- Priority is `rst` > `flush` > `freeze`.
  - `flush`: the output register loads a bubble and the FSM is forced to IDLE, abandoning any multiply in progress.
  - `freeze`: the output register, FSM, `acc`, `mcand`, `mplier` and `cnt` all hold. `stall` is evaluated on the held state.

## Timing
- Reset values:
  - All outputs 0; FSM in IDLE; `cnt`, `acc`, `mcand`, `mplier` all 0.
  - `stall` follows its equation, so it is high if `valid_in & mul_en` is asserted during reset.
- ALU op latency: 1 cycle, input cycle t gives output in cycle t+1.
- MUL latency when accepted in cycle 0 with no freeze:
  - BUSY in cycles 1..STEPS.
  - `stall` high in cycles 0..STEPS-1, low in cycle STEPS.
  - `valid_out` high in cycle STEPS+1; with defaults that is cycle 17.
- Back-to-back multiplies: the second is accepted in the cycle after the first's last BUSY cycle. There are no dead cycles beyond the launch cycle.
- `freeze` during BUSY extends the latency by exactly the number of frozen cycles.
- `flush` during BUSY: `valid_out=0` on the next cycle; a new instruction can be accepted in the cycle after the flush.

## Test plan
- Reset, then ADD with Rn=0x7FFFFFFF, Val_2=1, S_in=1 -> next cycle `ALU_result=0x80000000`, status N=1 Z=0 C=0 V=1, `status_we=1`.
- SUB with Rn=5, Val_2=5 -> `ALU_result=0`, Z=1, C=1; then MVN with Val_2=0 -> `0xFFFFFFFF`, with C/V equal to `SR`.
- MUL with Rm=0x12345678, Rs=0x10 -> `stall` high 16 cycles, `valid_out` in cycle 17 with `0x23456780`. Bubbles are seen in cycles 1..16.
- MLA with Rm=0xFFFFFFFF, Rs=3, Rn=4 -> `ALU_result=0x00000001`, N=0 Z=0, C/V from `SR`. Repeat with BPC=1 and BPC=4: latencies are 33 and 9 cycles.
- MUL launched, `freeze` asserted for 3 cycles mid-BUSY -> result arrives in cycle 20, with the value unchanged.
- MUL launched, `flush` in cycle 5 -> `valid_out=0` in cycle 6, FSM IDLE. A following ADD 2+3 yields 5 one cycle after it is presented.
